// File: rtl/ir_beacon_classifier.sv
// rtl/ir_beacon_classifier.sv - debounced 1 kHz / 10 kHz IR beacon classifier
//
// Samples the per-window ir1k / ir10k match flags once per measurement window.
// A class is declared only after LOCK_COUNT consecutive agreeing windows. The
// lock survives up to DROP_COUNT-1 consecutive empty windows.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low
//   enable     - block enable; low clears everything every cycle
//   ir1k       - 1 kHz match flag (level)
//   ir10k      - 10 kHz match flag (level)
//   beacon_1k  - locked or holding on a 1 kHz beacon
//   beacon_10k - locked or holding on a 10 kHz beacon
//   lock_pulse - one-cycle pulse on CAND -> LOCKED
//   lost_pulse - one-cycle pulse when an established lock is abandoned
//   state      - FSM state: NONE=00, CAND=01, LOCKED=10, HOLD=11
module ir_beacon_classifier #(
  parameter int WINDOW_CYCLES = 10_000_000,
  parameter int LOCK_COUNT    = 3,
  parameter int DROP_COUNT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ir1k,
  input  logic       ir10k,
  output logic       beacon_1k,
  output logic       beacon_10k,
  output logic       lock_pulse,
  output logic       lost_pulse,
  output logic [1:0] state
);

  localparam int             CW     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST   = CW'(WINDOW_CYCLES - 1);
  localparam logic [3:0]     LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0]     DROP_N = 4'(DROP_COUNT);

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_1K    = 2'b01;
  localparam logic [1:0] C_10K   = 2'b10;

  typedef enum logic [1:0] {
    S_NONE   = 2'b00,
    S_CAND   = 2'b01,
    S_LOCKED = 2'b10,
    S_HOLD   = 2'b11
  } state_t;

  logic [CW-1:0] win_cnt;
  state_t        st_q, st_d;
  logic [1:0]    cls_q, cls_d;
  logic [3:0]    match_q, match_d, miss_q, miss_d;
  logic [3:0]    match_inc, miss_inc;
  logic          lock_d, lost_d;
  logic          sample;
  logic [1:0]    code;

  assign sample = (win_cnt == LAST);
  // Both flags set is ambiguous, so only exactly-one-flag patterns name a class.
  assign code   = (ir10k ^ ir1k) ? {ir10k, ir1k} : C_EMPTY;

  // Saturating increments; equality-triggered transitions keep them from
  // reaching the ceiling in practice.
  assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;
  assign miss_inc  = (miss_q  == 4'hF) ? miss_q  : miss_q  + 4'd1;

  always_comb begin
    st_d    = st_q;
    cls_d   = cls_q;
    match_d = match_q;
    miss_d  = miss_q;
    lock_d  = 1'b0;
    lost_d  = 1'b0;
    if (sample) begin
      case (st_q)
        S_NONE: begin
          if (code != C_EMPTY) begin
            st_d    = S_CAND;
            cls_d   = code;
            match_d = 4'd1;
          end
        end
        S_CAND: begin
          if (code == C_EMPTY) begin
            st_d    = S_NONE;
            cls_d   = C_EMPTY;
            match_d = 4'd0;
          end else if (code == cls_q) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              st_d   = S_LOCKED;
              miss_d = 4'd0;
              lock_d = 1'b1;
            end
          end else begin
            cls_d   = code;
            match_d = 4'd1;
          end
        end
        S_LOCKED, S_HOLD: begin
          if (code == cls_q) begin
            // Returning from HOLD is a continuation of the same lock: no pulse.
            st_d   = S_LOCKED;
            miss_d = 4'd0;
          end else if (code == C_EMPTY) begin
            miss_d = miss_inc;
            if (miss_inc == DROP_N) begin
              st_d    = S_NONE;
              cls_d   = C_EMPTY;
              match_d = 4'd0;
              miss_d  = 4'd0;
              lost_d  = 1'b1;
            end else begin
              st_d = S_HOLD;
            end
          end else begin
            st_d    = S_CAND;
            cls_d   = code;
            match_d = 4'd1;
            miss_d  = 4'd0;
            lost_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // Disable behaves exactly like reset, so a killed lock never reports lost.
    if (!reset || !enable) begin
      win_cnt    <= '0;
      st_q       <= S_NONE;
      cls_q      <= C_EMPTY;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      lock_pulse <= 1'b0;
      lost_pulse <= 1'b0;
    end else begin
      win_cnt    <= sample ? '0 : win_cnt + 1'b1;
      st_q       <= st_d;
      cls_q      <= cls_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      lock_pulse <= lock_d;
      lost_pulse <= lost_d;
    end
  end

  assign state      = st_q;
  assign beacon_1k  = st_q[1] && (cls_q == C_1K);
  assign beacon_10k = st_q[1] && (cls_q == C_10K);

endmodule

// File: tb/tb_ir_beacon_classifier.sv
// tb/tb_ir_beacon_classifier.sv - self-checking bench for ir_beacon_classifier
module tb_ir_beacon_classifier;

  localparam int WIN  = 10;
  localparam int LOCK = 3;
  localparam int DROP = 2;

  logic       clk = 1'b0;
  logic       reset, enable, ir1k, ir10k;
  logic       beacon_1k, beacon_10k, lock_pulse, lost_pulse;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int glitch = 0;

  // Reference model: current lock class (0 none, 1 = 1K, 2 = 10K), candidate
  // class with its run length, and the run of empty windows under a lock.
  int   m_lock, m_cand, m_run, m_empt;
  logic m_lockp, m_lostp;

  ir_beacon_classifier #(
    .WINDOW_CYCLES(WIN),
    .LOCK_COUNT(LOCK),
    .DROP_COUNT(DROP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ir1k(ir1k),
    .ir10k(ir10k),
    .beacon_1k(beacon_1k),
    .beacon_10k(beacon_10k),
    .lock_pulse(lock_pulse),
    .lost_pulse(lost_pulse),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] dut_vec();
    return {state, beacon_10k, beacon_1k, lock_pulse, lost_pulse};
  endfunction

  function automatic logic [5:0] mdl_vec();
    logic [1:0] s;
    if (m_lock != 0)      s = (m_empt > 0) ? 2'b11 : 2'b10;
    else if (m_cand != 0) s = 2'b01;
    else                  s = 2'b00;
    return {s, (m_lock == 2), (m_lock == 1), m_lockp, m_lostp};
  endfunction

  task automatic model_clear();
    m_lock = 0; m_cand = 0; m_run = 0; m_empt = 0;
    m_lockp = 1'b0; m_lostp = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] code);
    int c;
    c = (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : 0;
    m_lockp = 1'b0;
    m_lostp = 1'b0;
    if (m_lock != 0) begin
      if (c == m_lock) m_empt = 0;
      else if (c == 0) begin
        m_empt++;
        if (m_empt == DROP) begin m_lock = 0; m_empt = 0; m_lostp = 1'b1; end
      end else begin
        m_lock = 0; m_empt = 0; m_lostp = 1'b1; m_cand = c; m_run = 1;
      end
    end else if (m_cand != 0) begin
      if (c == m_cand) begin
        m_run++;
        if (m_run == LOCK) begin m_lock = c; m_cand = 0; m_run = 0; m_empt = 0; m_lockp = 1'b1; end
      end else if (c == 0) begin m_cand = 0; m_run = 0; end
      else begin m_cand = c; m_run = 1; end
    end else if (c != 0) begin
      m_cand = c; m_run = 1;
    end
  endtask

  // One full window starting at a negedge aligned to window position 0.
  // Flags are random except on the sample cycle; between samples nothing may move.
  task automatic run_window(input logic [1:0] code);
    logic [1:0] st0;
    st0 = state;
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) {ir10k, ir1k} = code;
      else              {ir10k, ir1k} = 2'($urandom);
      @(negedge clk);
      if (i < WIN - 1 && (lock_pulse || lost_pulse || state !== st0)) glitch++;
    end
    model_step(code);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b1;
    {ir10k, ir1k} = 2'($urandom);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    glitch = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; ir1k = 1'b1; ir10k = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b000000) begin
      errors++; $display("FAIL reset_state got %b want %b", dut_vec(), 6'b000000);
    end
    reset = 1'b1;
    model_clear();
    glitch = 0;
  endtask

  task automatic test_lock_1k();
    do_reset();
    run_window(2'b01);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL lock1k_cand got %b want %b", state, 2'b01); end
    run_window(2'b01);
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL lock1k_second got %b want %b", dut_vec(), mdl_vec()); end
    run_window(2'b01);
    checks++;
    if (dut_vec() !== 6'b100110) begin errors++; $display("FAIL lock1k_locked got %b want %b", dut_vec(), 6'b100110); end
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL lock1k_model got %b want %b", dut_vec(), mdl_vec()); end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL lock1k_glitch got %0d want 0", glitch); end
  endtask

  task automatic test_hold_10k();
    do_reset();
    repeat (3) run_window(2'b10);
    run_window(2'b00);
    checks++;
    if (dut_vec() !== 6'b111000) begin errors++; $display("FAIL hold_enter got %b want %b", dut_vec(), 6'b111000); end
    run_window(2'b10);
    checks++;
    if (dut_vec() !== 6'b101000) begin errors++; $display("FAIL hold_return got %b want %b", dut_vec(), 6'b101000); end
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hold_model got %b want %b", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_drop_10k();
    do_reset();
    repeat (3) run_window(2'b10);
    run_window(2'b00);
    run_window(2'b00);
    checks++;
    if (dut_vec() !== 6'b000001) begin errors++; $display("FAIL drop_lost got %b want %b", dut_vec(), 6'b000001); end
    run_window(2'b00);
    checks++;
    if (dut_vec() !== 6'b000000) begin errors++; $display("FAIL drop_after got %b want %b", dut_vec(), 6'b000000); end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL drop_glitch got %0d want 0", glitch); end
  endtask

  task automatic test_switch();
    do_reset();
    repeat (3) run_window(2'b01);
    run_window(2'b10);
    checks++;
    if (dut_vec() !== 6'b010001) begin errors++; $display("FAIL switch_lost got %b want %b", dut_vec(), 6'b010001); end
    run_window(2'b10);
    checks++;
    if (dut_vec() !== 6'b010000) begin errors++; $display("FAIL switch_cand got %b want %b", dut_vec(), 6'b010000); end
    run_window(2'b10);
    checks++;
    if (dut_vec() !== 6'b101010) begin errors++; $display("FAIL switch_relock got %b want %b", dut_vec(), 6'b101010); end
  endtask

  task automatic test_invalid();
    do_reset();
    run_window(2'b01);
    run_window(2'b01);
    run_window(2'b11);
    checks++;
    if (dut_vec() !== 6'b000000) begin errors++; $display("FAIL invalid_empty got %b want %b", dut_vec(), 6'b000000); end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL invalid_glitch got %0d want 0", glitch); end
  endtask

  task automatic test_kill(input logic use_reset);
    do_reset();
    repeat (3) run_window(2'b01);
    checks++;
    if (dut_vec() !== 6'b100110) begin errors++; $display("FAIL kill_prelock got %b want %b", dut_vec(), 6'b100110); end
    for (int i = 0; i < 4; i++) begin
      {ir10k, ir1k} = 2'b01;
      @(negedge clk);
    end
    if (use_reset) reset = 1'b0;
    else           enable = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b000000) begin errors++; $display("FAIL kill_cleared got %b want %b", dut_vec(), 6'b000000); end
    reset = 1'b1;
    enable = 1'b1;
    model_clear();
    run_window(2'b01);
    run_window(2'b01);
    checks++;
    if (dut_vec() !== 6'b010000) begin errors++; $display("FAIL kill_fresh got %b want %b", dut_vec(), 6'b010000); end
    run_window(2'b01);
    checks++;
    if (dut_vec() !== 6'b100110) begin errors++; $display("FAIL kill_relock got %b want %b", dut_vec(), 6'b100110); end
  endtask

  task automatic test_random();
    logic [1:0] code;
    do_reset();
    code = 2'b01;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) >= 70) code = 2'($urandom);
      run_window(code);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random_win%0d got %b want %b", n, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL random_glitch got %0d want 0", glitch); end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; ir1k = 1'b0; ir10k = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock_1k();
    test_hold_10k();
    test_drop_10k();
    test_switch();
    test_invalid();
    test_kill(1'b0);
    test_kill(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
